// File: rtl/rv32i_pkg.sv
// Shared RV32I core types and sizes.
// Used by the register-file writeback path and its load queue.
package rv32i_pkg;

  localparam int XLEN         = 32;
  localparam int REG_AW       = 5;
  localparam int NUM_REGS     = 32;
  localparam int LQ_DEPTH_DEF = 2;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   xlen_t;

  typedef struct packed {
    reg_addr_t rd;
    xlen_t     data;
  } lq_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO, power-of-2 depth.
// A separate occupancy count tells full from empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           din_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din_i;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + CW'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/rf_writeback_unit.sv
// Register-file write port arbiter: ALU results first, then queued loads.
// Tracks in-flight loads and raises stall_o on RAW/WAW hazards.
module rf_writeback_unit
  import rv32i_pkg::*;
#(
  parameter int LQ_DEPTH = LQ_DEPTH_DEF
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              alu_valid_i,
  input  logic [REG_AW-1:0] alu_rd_i,
  input  logic [XLEN-1:0]   alu_data_i,
  input  logic              ld_issue_i,
  input  logic [REG_AW-1:0] ld_issue_rd_i,
  input  logic              ld_valid_i,
  output logic              ld_ready_o,
  input  logic [REG_AW-1:0] ld_rd_i,
  input  logic [XLEN-1:0]   ld_data_i,
  input  logic [REG_AW-1:0] dec_rs1_i,
  input  logic [REG_AW-1:0] dec_rs2_i,
  input  logic [REG_AW-1:0] dec_rd_i,
  output logic              stall_o,
  output logic              we3_o,
  output logic [REG_AW-1:0] a3_o,
  output logic [XLEN-1:0]   wd3_o
);

  localparam int CW = $clog2(LQ_DEPTH + 1);

  lq_entry_t           push_entry, head;
  logic                fifo_full, fifo_empty;
  logic                push, pop;
  logic [CW-1:0]       lq_count;
  logic                we3_q, we3_d;
  logic [REG_AW-1:0]   a3_q, a3_d;
  logic [XLEN-1:0]     wd3_q, wd3_d;
  logic [NUM_REGS-1:0] pending_q, pending_d;

  assign push_entry = '{rd: ld_rd_i, data: ld_data_i};
  assign ld_ready_o = !fifo_full;
  assign push       = ld_valid_i && ld_ready_o;
  // Loads never bypass the queue; the head drains only on ALU-idle cycles.
  assign pop        = !alu_valid_i && !fifo_empty;

  sync_fifo #(
    .WIDTH($bits(lq_entry_t)),
    .DEPTH(LQ_DEPTH)
  ) u_lq (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (push),
    .din_i   (push_entry),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (lq_count)
  );

  always_comb begin
    we3_d = 1'b0;
    a3_d  = a3_q;
    wd3_d = wd3_q;
    unique case (1'b1)
      alu_valid_i: begin
        if (alu_rd_i != '0) begin
          we3_d = 1'b1;
          a3_d  = alu_rd_i;
          wd3_d = alu_data_i;
        end
      end
      pop: begin
        if (head.rd != '0) begin
          we3_d = 1'b1;
          a3_d  = head.rd;
          wd3_d = head.data;
        end
      end
      default: ;
    endcase
  end

  // A new issue to the same rd outranks the retiring pop.
  always_comb begin
    pending_d = pending_q;
    if (pop) begin
      pending_d[head.rd] = 1'b0;
    end
    if (ld_issue_i) begin
      pending_d[ld_issue_rd_i] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  assign stall_o = pending_q[dec_rs1_i] | pending_q[dec_rs2_i] |
                   pending_q[dec_rd_i];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      we3_q     <= 1'b0;
      a3_q      <= '0;
      wd3_q     <= '0;
      pending_q <= '0;
    end else begin
      we3_q     <= we3_d;
      a3_q      <= a3_d;
      wd3_q     <= wd3_d;
      pending_q <= pending_d;
    end
  end

  assign we3_o = we3_q;
  assign a3_o  = a3_q;
  assign wd3_o = wd3_q;

  a_alu_waw: assert property (@(posedge clk_i) disable iff (reset_i)
    !(alu_valid_i && pending_q[alu_rd_i]));

  a_lq_count: assert property (@(posedge clk_i)
    lq_count <= CW'(LQ_DEPTH));

endmodule
